// File: rtl/board_state_keeper.sv
// 10x10 game board with display read port, validated placement and
// sequential 4-in-a-row detection through the most recently placed cell.
module board_state_keeper #(
  parameter int BOARD_N = 10,
  parameter int WIN_LEN = 4,
  parameter int CELLS   = BOARD_N * BOARD_N
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  output logic [1:0] board_data,
  input  logic       new_game,
  input  logic       place_valid,
  input  logic [3:0] place_x,
  input  logic [3:0] place_y,
  output logic       place_ready,
  output logic       place_done,
  output logic       place_ok,
  output logic [1:0] turn,
  output logic [3:0] movTrig,
  output logic [3:0] movCirc,
  output logic [4:0] rpx,
  output logic [4:0] rpy,
  output logic       winCondition,
  output logic [4:0] scoreTri,
  output logic [4:0] scoreCirc
);

  typedef enum logic [2:0] {
    CLEAR, IDLE, CHECK, WRITE, SCAN, DONE
  } state_t;

  state_t state;

  logic [1:0] mem [CELLS];

  logic [6:0]        clr_idx;
  logic [3:0]        cx, cy;
  logic [1:0]        dir;
  logic              neg;
  logic [2:0]        step;
  logic [2:0]        cnt;
  logic signed [5:0] px, py;
  logic              ng_pend;

  logic              in_board;
  logic [6:0]        cell_addr;
  logic [1:0]        cell_val;
  logic              probe_in;
  logic [6:0]        probe_addr;
  logic              probe_match;
  logic              scan_win, walk_more, scan_end;
  logic [1:0]        ndir;
  logic signed [5:0] cxs, cys;
  logic              mem_we;
  logic [6:0]        mem_wa;
  logic [1:0]        mem_wd;

  // Axis step: 0 E-W, 1 N-S, 2 NE-SW, 3 NW-SE
  function automatic logic signed [5:0] dxf(input logic [1:0] d);
    return (d == 2'd1) ? 6'sd0 : 6'sd1;
  endfunction

  function automatic logic signed [5:0] dyf(input logic [1:0] d);
    logic signed [5:0] r;
    unique case (d)
      2'd0:    r = 6'sd0;
      2'd2:    r = -6'sd1;
      default: r = 6'sd1;
    endcase
    return r;
  endfunction

  always_comb begin
    cxs = $signed({2'b00, cx});
    cys = $signed({2'b00, cy});
    ndir = dir + 2'd1;
    in_board = (cx < 4'(BOARD_N)) && (cy < 4'(BOARD_N));
    cell_addr = 7'(cx) + 7'(cy) * 7'(BOARD_N);
    cell_val = in_board ? mem[cell_addr] : 2'b00;
    probe_in = !px[5] && !py[5]
            && (px[4:0] < 5'(BOARD_N))
            && (py[4:0] < 5'(BOARD_N));
    probe_addr = 7'(px[3:0]) + 7'(py[3:0]) * 7'(BOARD_N);
    probe_match = probe_in && (mem[probe_addr] == turn);
    scan_win = probe_match && (cnt == 3'(WIN_LEN - 1));
    walk_more = probe_match && (step != 3'(WIN_LEN - 2));
    scan_end = !scan_win && !walk_more && neg && (dir == 2'd3);
  end

  always_comb begin
    mem_we = (state == CLEAR) || (state == WRITE);
    mem_wa = (state == CLEAR) ? clr_idx : cell_addr;
    mem_wd = (state == CLEAR) ? 2'b00 : turn;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Nonblocking write makes a same-cycle read return the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) board_data <= 2'b00;
    else if (state == CLEAR || addr >= 7'(CELLS)) board_data <= 2'b00;
    else board_data <= mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      cx           <= '0;
      cy           <= '0;
      dir          <= '0;
      neg          <= 1'b0;
      step         <= '0;
      cnt          <= '0;
      px           <= '0;
      py           <= '0;
      ng_pend      <= 1'b0;
      place_ready  <= 1'b0;
      place_done   <= 1'b0;
      place_ok     <= 1'b0;
      turn         <= 2'b01;
      movTrig      <= '0;
      movCirc      <= '0;
      rpx          <= '0;
      rpy          <= '0;
      winCondition <= 1'b0;
      scoreTri     <= '0;
      scoreCirc    <= '0;
    end else begin
      place_done <= 1'b0;
      if (new_game && state != IDLE) ng_pend <= 1'b1;
      unique case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 7'd1;
          if (clr_idx == 7'(CELLS - 1)) begin
            state        <= IDLE;
            place_ready  <= 1'b1;
            movTrig      <= '0;
            movCirc      <= '0;
            rpx          <= '0;
            rpy          <= '0;
            winCondition <= 1'b0;
            turn         <= 2'b01;
          end
        end
        IDLE: begin
          if (new_game || ng_pend) begin
            ng_pend     <= 1'b0;
            clr_idx     <= '0;
            place_ready <= 1'b0;
            state       <= CLEAR;
          end else if (place_valid) begin
            cx          <= place_x;
            cy          <= place_y;
            place_ready <= 1'b0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (!in_board || cell_val != 2'b00 || winCondition) begin
            place_ok   <= 1'b0;
            place_done <= 1'b1;
            state      <= DONE;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          dir   <= 2'd0;
          neg   <= 1'b0;
          step  <= '0;
          cnt   <= 3'd1;
          px    <= cxs + dxf(2'd0);
          py    <= cys + dyf(2'd0);
          state <= SCAN;
        end
        SCAN: begin
          if (scan_win || scan_end) begin
            place_ok   <= 1'b1;
            place_done <= 1'b1;
            rpx        <= {1'b0, cx};
            rpy        <= {1'b0, cy};
            if (turn == 2'b01) begin
              if (movTrig != 4'hF) movTrig <= movTrig + 4'd1;
            end else begin
              if (movCirc != 4'hF) movCirc <= movCirc + 4'd1;
            end
            if (scan_win) begin
              winCondition <= 1'b1;
              if (turn == 2'b01) begin
                if (scoreTri != 5'h1F) scoreTri <= scoreTri + 5'd1;
              end else begin
                if (scoreCirc != 5'h1F) scoreCirc <= scoreCirc + 5'd1;
              end
            end else begin
              turn <= ~turn;
            end
            state <= DONE;
          end else if (walk_more) begin
            cnt  <= cnt + 3'd1;
            step <= step + 3'd1;
            px   <= neg ? px - dxf(dir) : px + dxf(dir);
            py   <= neg ? py - dyf(dir) : py + dyf(dir);
          end else begin
            step <= '0;
            if (!neg) begin
              neg <= 1'b1;
              cnt <= probe_match ? cnt + 3'd1 : cnt;
              px  <= cxs - dxf(dir);
              py  <= cys - dyf(dir);
            end else begin
              dir <= ndir;
              neg <= 1'b0;
              cnt <= 3'd1;
              px  <= cxs + dxf(ndir);
              py  <= cys + dyf(ndir);
            end
          end
        end
        DONE: begin
          place_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_keeper.sv
// Scoreboard bench for board_state_keeper: directed game scenarios plus
// random placements checked against an array-based game model.
module tb_board_state_keeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = '0;
  logic [1:0] board_data;
  logic       new_game = 1'b0;
  logic       place_valid = 1'b0;
  logic [3:0] place_x = '0;
  logic [3:0] place_y = '0;
  logic       place_ready, place_done, place_ok;
  logic [1:0] turn;
  logic [3:0] movTrig, movCirc;
  logic [4:0] rpx, rpy;
  logic       winCondition;
  logic [4:0] scoreTri, scoreCirc;

  board_state_keeper dut (
    .clk(clk), .rst(rst), .addr(addr), .board_data(board_data),
    .new_game(new_game), .place_valid(place_valid),
    .place_x(place_x), .place_y(place_y),
    .place_ready(place_ready), .place_done(place_done),
    .place_ok(place_ok), .turn(turn),
    .movTrig(movTrig), .movCirc(movCirc), .rpx(rpx), .rpy(rpy),
    .winCondition(winCondition),
    .scoreTri(scoreTri), .scoreCirc(scoreCirc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ok; int turn; int mt; int mc;
    int rx; int ry; int win; int st; int sc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;

  int bd[10][10];
  int m_turn, m_mt, m_mc, m_rx, m_ry, m_win, m_st, m_sc;

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int run_len(int x, int y, int s, int dx, int dy);
    int n = 1;
    for (int sg = -1; sg <= 1; sg += 2) begin
      for (int k = 1; k < 4; k++) begin
        int xx = x + sg * k * dx;
        int yy = y + sg * k * dy;
        if (xx < 0 || xx > 9 || yy < 0 || yy > 9) break;
        if (bd[xx][yy] != s) break;
        n++;
      end
    end
    return n;
  endfunction

  function automatic bit model_wins(int x, int y, int s);
    return run_len(x, y, s, 1, 0) >= 4 || run_len(x, y, s, 0, 1) >= 4
        || run_len(x, y, s, 1, -1) >= 4 || run_len(x, y, s, 1, 1) >= 4;
  endfunction

  task automatic model_new_game();
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) bd[i][j] = 0;
    m_turn = 1; m_mt = 0; m_mc = 0; m_rx = 0; m_ry = 0; m_win = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && place_done) begin
      done_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("place_ok", int'(place_ok), mon_e.ok);
        chk("turn", int'(turn), mon_e.turn);
        chk("movTrig", int'(movTrig), mon_e.mt);
        chk("movCirc", int'(movCirc), mon_e.mc);
        chk("rpx", int'(rpx), mon_e.rx);
        chk("rpy", int'(rpy), mon_e.ry);
        chk("winCondition", int'(winCondition), mon_e.win);
        chk("scoreTri", int'(scoreTri), mon_e.st);
        chk("scoreCirc", int'(scoreCirc), mon_e.sc);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (place_ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic place(input int x, input int y);
    exp_t e;
    int d0;
    bit ok;
    wait_ready();
    ok = x < 10 && y < 10 && m_win == 0;
    if (ok) ok = bd[x][y] == 0;
    if (ok) begin
      bd[x][y] = m_turn;
      if (m_turn == 1) m_mt = (m_mt < 15) ? m_mt + 1 : 15;
      else m_mc = (m_mc < 15) ? m_mc + 1 : 15;
      m_rx = x; m_ry = y;
      if (model_wins(x, y, m_turn)) begin
        m_win = 1;
        if (m_turn == 1) m_st = (m_st < 31) ? m_st + 1 : 31;
        else m_sc = (m_sc < 31) ? m_sc + 1 : 31;
      end else begin
        m_turn = 3 - m_turn;
      end
    end
    e = '{ok: int'(ok), turn: m_turn, mt: m_mt, mc: m_mc, rx: m_rx,
          ry: m_ry, win: m_win, st: m_st, sc: m_sc};
    q.push_back(e);
    d0 = done_cnt;
    place_x = 4'(x);
    place_y = 4'(y);
    place_valid = 1'b1;
    @(negedge clk);
    place_valid = 1'b0;
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic check_board();
    @(negedge clk);
    addr = 7'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk($sformatf("cell%0d", i), int'(board_data), bd[i % 10][i / 10]);
      addr = 7'(i + 1);
    end
    @(negedge clk);
    chk("addr100", int'(board_data), 0);
    addr = 7'd127;
    @(negedge clk);
    chk("addr127", int'(board_data), 0);
    addr = 7'd0;
  endtask

  task automatic check_status();
    chk("st_turn", int'(turn), m_turn);
    chk("st_win", int'(winCondition), m_win);
    chk("st_movTrig", int'(movTrig), m_mt);
    chk("st_movCirc", int'(movCirc), m_mc);
    chk("st_rpx", int'(rpx), m_rx);
    chk("st_rpy", int'(rpy), m_ry);
    chk("st_scoreTri", int'(scoreTri), m_st);
    chk("st_scoreCirc", int'(scoreCirc), m_sc);
  endtask

  // with_req also raises place_valid in the same cycle; it must be dropped
  task automatic start_new_game(input bit with_req, input bit full);
    int n = 0;
    int d0;
    wait_ready();
    d0 = done_cnt;
    new_game = 1'b1;
    place_valid = with_req;
    place_x = 4'd5;
    place_y = 4'd5;
    @(negedge clk);
    new_game = 1'b0;
    place_valid = 1'b0;
    for (int i = 0; i < 300 && !place_ready; i++) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, 100);
    chk("no_done_on_new_game", done_cnt, d0);
    model_new_game();
    check_status();
    if (full) check_board();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    m_st = 0;
    m_sc = 0;
    model_new_game();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", int'(place_ready), 0);
    chk("reset_done", int'(place_done), 0);
    wait_ready();
    check_status();
    check_board();

    place(3, 2);
    check_board();
    place(3, 2);
    place(10, 0);
    place(0, 10);
    check_status();

    start_new_game(1'b0, 1'b0);
    place(0, 0); place(0, 5);
    place(1, 0); place(1, 5);
    place(2, 0); place(2, 5);
    place(3, 0);
    place(5, 5);
    check_board();

    start_new_game(1'b0, 1'b0);
    place(0, 9); place(6, 1);
    place(2, 9); place(5, 2);
    place(4, 9); place(3, 4);
    place(6, 9); place(4, 3);
    place(9, 9);

    start_new_game(1'b1, 1'b1);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 3) start_new_game(1'b0, 1'b0);
      else place(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
      if (it % 100 == 99) check_board();
    end

    start_new_game(1'b0, 1'b0);
    wait_ready();
    place_x = 4'd3;
    place_y = 4'd3;
    place_valid = 1'b1;
    @(negedge clk);
    place_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready();
    chk("no_done_after_rst", done_cnt, d0);
    m_st = 0;
    m_sc = 0;
    model_new_game();
    check_status();
    check_board();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
